// File: rtl/ysyx_22050612_mdu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_mdu_pkg : op codes and FSM encoding for the multiply/divide unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ysyx_22050612_mdu_pkg;

  localparam int unsigned MDU_OP_W = 4;

  localparam int unsigned MDU_MUL    = 0;
  localparam int unsigned MDU_MULH   = 1;
  localparam int unsigned MDU_MULHSU = 2;
  localparam int unsigned MDU_MULHU  = 3;
  localparam int unsigned MDU_DIV    = 4;
  localparam int unsigned MDU_DIVU   = 5;
  localparam int unsigned MDU_REM    = 6;
  localparam int unsigned MDU_REMU   = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050612_mdu_iter.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_mdu_iter : unsigned radix-2 shift-add / restoring shift-subtract step
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_22050612_mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic              word_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  // Multiply: acc = running product. Divide: acc = {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              is_div_q, is_div_d;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_rem_sub;

  assign w_rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, mcand_q[XLEN-1:0]};

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    is_div_d = is_div_q;
    if (load_i) begin
      is_div_d = is_div_i;
      if (is_div_i) begin
        // 32-bit dividends are left-aligned so the first step sees their MSB
        acc_d    = {{XLEN{1'b0}}, (word_i ? (a_i << 32) : a_i)};
        mcand_d  = {{XLEN{1'b0}}, b_i};
        mplier_d = '0;
      end else begin
        acc_d    = '0;
        mcand_d  = {{XLEN{1'b0}}, a_i};
        mplier_d = b_i;
      end
    end else if (step_i) begin
      if (is_div_q) begin
        if (!w_rem_sub[XLEN]) begin
          acc_d = {w_rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {w_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050612_mdu.sv
// ----------------------------------------------------------------------------
// ysyx_22050612_mdu : multi-cycle RV64M multiply/divide unit with valid/ready handshake
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_22050612_mdu
  import ysyx_22050612_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OP_W  = MDU_OP_W,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic op_is(input logic [OP_W-1:0] op, input int unsigned code);
    return op == OP_W'(code);
  endfunction

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_q;
  logic              word_q;
  logic              neg_q;
  logic [TAG_W-1:0]  tag_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  out_tag_q;

  logic              w_accept, w_is_mulh, w_rsvd, w_is_div, w_is_rem;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_div0, w_ovf, w_special;
  logic [OP_W-1:0]   w_op_eff;
  logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_res, w_min, w_spec_res;
  logic [2*XLEN-1:0] w_acc, w_prod;
  logic [XLEN-1:0]   w_dsel, w_dval, w_fix_raw, w_fix_res;

  assign in_ready = (state_q == S_IDLE) && !flush;
  assign w_accept = in_valid && in_ready;

  // W-form high multiplies collapse to MULW
  assign w_is_mulh = op_is(in_op, MDU_MULH) || op_is(in_op, MDU_MULHSU) || op_is(in_op, MDU_MULHU);
  assign w_op_eff  = (in_word && w_is_mulh) ? OP_W'(MDU_MUL) : in_op;
  assign w_rsvd    = in_op > OP_W'(MDU_REMU);
  assign w_is_div  = !w_rsvd && (w_op_eff >= OP_W'(MDU_DIV));
  assign w_is_rem  = op_is(w_op_eff, MDU_REM) || op_is(w_op_eff, MDU_REMU);
  assign w_a_sgn   = op_is(w_op_eff, MDU_MULH) || op_is(w_op_eff, MDU_MULHSU) ||
                     op_is(w_op_eff, MDU_DIV)  || op_is(w_op_eff, MDU_REM);
  assign w_b_sgn   = op_is(w_op_eff, MDU_MULH) || op_is(w_op_eff, MDU_DIV) ||
                     op_is(w_op_eff, MDU_REM);

  assign w_a_ext = in_word ? (w_a_sgn ? sext32(in_a[31:0]) : XLEN'(in_a[31:0])) : in_a;
  assign w_b_ext = in_word ? (w_b_sgn ? sext32(in_b[31:0]) : XLEN'(in_b[31:0])) : in_b;
  assign w_a_neg = w_a_sgn && w_a_ext[XLEN-1];
  assign w_b_neg = w_b_sgn && w_b_ext[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_a_res = in_word ? sext32(in_a[31:0]) : in_a;
  assign w_min   = in_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div0  = w_is_div && (w_b_ext == '0);
  assign w_ovf   = w_is_div && w_a_sgn && (w_a_ext == w_min) && (w_b_ext == '1);
  assign w_special = w_rsvd || w_div0 || w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_rsvd) begin
      w_spec_res = '0;
    end else if (w_div0) begin
      w_spec_res = w_is_rem ? w_a_res : '1;
    end else if (w_ovf) begin
      w_spec_res = w_is_rem ? '0 : w_min;
    end
  end

  ysyx_22050612_mdu_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (w_accept && !w_special),
    .step_i   (state_q == S_CALC),
    .is_div_i (w_is_div),
    .word_i   (in_word),
    .a_i      (w_a_mag),
    .b_i      (w_b_mag),
    .acc_o    (w_acc)
  );

  // Sign fix-up: products negate the full double-width value, remainders follow the dividend
  assign w_prod    = neg_q ? -w_acc : w_acc;
  assign w_dsel    = (op_is(op_q, MDU_REM) || op_is(op_q, MDU_REMU)) ?
                     w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
  assign w_dval    = neg_q ? -w_dsel : w_dsel;
  assign w_fix_raw = (op_q >= OP_W'(MDU_DIV)) ? w_dval :
                     op_is(op_q, MDU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_fix_res = word_q ? sext32(w_fix_raw[31:0]) : w_fix_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            op_q   <= w_op_eff;
            word_q <= in_word;
            neg_q  <= w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
            tag_q  <= in_tag;
            if (w_special) begin
              result_q    <= w_spec_res;
              out_tag_q   <= in_tag;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              cnt_q   <= in_word ? CNT_W'(31) : CNT_W'(XLEN-1);
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          result_q    <= w_fix_res;
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = out_tag_q;

endmodule

`default_nettype wire
